// File: rtl/jtag_tdr_csr_tgt_if.sv
// CSR request/completion bus between the JTAG TDR target (master) and the CSR block (slave).
interface jtag_tdr_csr_tgt_if;
   logic [27:0] CsrAddr;
   logic [15:0] CsrWrData;
   logic        CsrWrEn;
   logic        CsrRdEn;
   logic        CsrAck;
   logic [15:0] CsrRdData;

   modport master (
      output CsrAddr, CsrWrData, CsrWrEn, CsrRdEn,
      input  CsrAck, CsrRdData
   );

   modport slave (
      input  CsrAddr, CsrWrData, CsrWrEn, CsrRdEn,
      output CsrAck, CsrRdData
   );
endinterface

// File: rtl/jtag_tdr_csr_tgt.sv
// JTAG TDR to CSR bridge: a 45-bit command TDR issues one CSR access; a 16-bit TDR returns read data.
// Optional WAIT timeout enabled by defining JTAG_TDR_CSR_TIMEOUT_EN.
module jtag_tdr_csr_tgt (
   input  logic                       TDRCLK,
   input  logic                       TDRRST,
   input  logic                       WSI,
   input  logic                       DdrPhyCsrCmdTdrCaptureEn,
   input  logic                       DdrPhyCsrCmdTdrShiftEn,
   input  logic                       DdrPhyCsrCmdTdrUpdateEn,
   output logic                       DdrPhyCsrCmdTdr_Tdo,
   input  logic                       DdrPhyCsrRdDataTdrCaptureEn,
   input  logic                       DdrPhyCsrRdDataTdrShiftEn,
   input  logic                       DdrPhyCsrRdDataTdrUpdateEn,
   output logic                       DdrPhyCsrRdDataTdr_Tdo,
   jtag_tdr_csr_tgt_if.master         csr,
   output logic                       CsrTdrOverrun,
   output logic                       CsrTdrTimeout
);

   typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} state_e;

   state_e      state_q, state_d;
   logic [44:0] cmd_sr_q, cmd_sr_d;
   logic [44:0] cmd_q, cmd_d;
   logic [15:0] hold_q, hold_d;
   logic [15:0] rsr_q, rsr_d;
   logic        overrun_q, overrun_d;
`ifdef JTAG_TDR_CSR_TIMEOUT_EN
   logic [7:0]  tmo_cnt_q, tmo_cnt_d;
   logic        timeout_q, timeout_d;
`endif

   logic busy;
   logic is_wr;

   always_ff @(posedge TDRCLK) begin
      if (TDRRST) begin
         state_q   <= ST_IDLE;
         cmd_sr_q  <= '0;
         cmd_q     <= '0;
         hold_q    <= '0;
         rsr_q     <= '0;
         overrun_q <= 1'b0;
`ifdef JTAG_TDR_CSR_TIMEOUT_EN
         tmo_cnt_q <= '0;
         timeout_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         cmd_sr_q  <= cmd_sr_d;
         cmd_q     <= cmd_d;
         hold_q    <= hold_d;
         rsr_q     <= rsr_d;
         overrun_q <= overrun_d;
`ifdef JTAG_TDR_CSR_TIMEOUT_EN
         tmo_cnt_q <= tmo_cnt_d;
         timeout_q <= timeout_d;
`endif
      end
   end

   always_comb begin
      state_d   = state_q;
      cmd_sr_d  = cmd_sr_q;
      cmd_d     = cmd_q;
      hold_d    = hold_q;
      rsr_d     = rsr_q;
      overrun_d = overrun_q;
`ifdef JTAG_TDR_CSR_TIMEOUT_EN
      tmo_cnt_d = tmo_cnt_q;
      timeout_d = timeout_q;
`endif

      if (DdrPhyCsrCmdTdrCaptureEn) begin
         cmd_sr_d = cmd_q;
      end else if (DdrPhyCsrCmdTdrShiftEn) begin
         cmd_sr_d = {WSI, cmd_sr_q[44:1]};
      end

      if (DdrPhyCsrRdDataTdrCaptureEn) begin
         rsr_d = hold_q;
      end else if (DdrPhyCsrRdDataTdrShiftEn) begin
         rsr_d = {1'b0, rsr_q[15:1]};
      end

      if (DdrPhyCsrRdDataTdrUpdateEn) begin
         overrun_d = 1'b0;
`ifdef JTAG_TDR_CSR_TIMEOUT_EN
         timeout_d = 1'b0;
`endif
      end

      case (state_q)
         ST_IDLE: begin
            if (DdrPhyCsrCmdTdrUpdateEn) begin
               cmd_d   = cmd_sr_q;
               state_d = ST_REQ;
            end
         end
         ST_REQ: begin
            if (csr.CsrAck) begin
               state_d = ST_IDLE;
               if (!cmd_q[28]) hold_d = csr.CsrRdData;
            end else begin
               state_d = ST_WAIT;
`ifdef JTAG_TDR_CSR_TIMEOUT_EN
               tmo_cnt_d = '0;
`endif
            end
         end
         ST_WAIT: begin
            if (csr.CsrAck) begin
               state_d = ST_IDLE;
               if (!cmd_q[28]) hold_d = csr.CsrRdData;
            end
`ifdef JTAG_TDR_CSR_TIMEOUT_EN
            // 255th WAIT cycle without an ack abandons the access
            else if (tmo_cnt_q == 8'd254) begin
               state_d   = ST_IDLE;
               timeout_d = 1'b1;
               if (!cmd_q[28]) hold_d = 16'hDEAD;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 8'd1;
            end
`endif
         end
         default: state_d = ST_IDLE;
      endcase

      // A new update while busy is dropped; the set wins over a same-edge clear
      if (DdrPhyCsrCmdTdrUpdateEn && (state_q != ST_IDLE)) begin
         overrun_d = 1'b1;
      end
   end

   assign busy  = (state_q != ST_IDLE);
   assign is_wr = cmd_q[28];

   assign csr.CsrAddr   = busy ? cmd_q[27:0] : 28'd0;
   assign csr.CsrWrData = (busy && is_wr) ? cmd_q[44:29] : 16'd0;
   assign csr.CsrWrEn   = busy && is_wr;
   assign csr.CsrRdEn   = busy && !is_wr;

   assign DdrPhyCsrCmdTdr_Tdo    = cmd_sr_q[0];
   assign DdrPhyCsrRdDataTdr_Tdo = rsr_q[0];
   assign CsrTdrOverrun          = overrun_q;
`ifdef JTAG_TDR_CSR_TIMEOUT_EN
   assign CsrTdrTimeout          = timeout_q;
`else
   assign CsrTdrTimeout          = 1'b0;
`endif

endmodule

// File: tb/tb_jtag_tdr_csr_tgt.sv
// Directed self-checking bench for jtag_tdr_csr_tgt (optional JTAG_TDR_CSR_TIMEOUT_EN scenario included).
module tb_jtag_tdr_csr_tgt;

   logic TDRCLK = 1'b0;
   logic TDRRST, WSI;
   logic cmd_cap, cmd_shift, cmd_upd;
   logic rd_cap, rd_shift, rd_upd;
   logic cmd_tdo, rd_tdo, ovr, tmo;
   int   checks = 0;
   int   errors = 0;

   jtag_tdr_csr_tgt_if csr_if ();

   jtag_tdr_csr_tgt dut (
      .TDRCLK                      (TDRCLK),
      .TDRRST                      (TDRRST),
      .WSI                         (WSI),
      .DdrPhyCsrCmdTdrCaptureEn    (cmd_cap),
      .DdrPhyCsrCmdTdrShiftEn      (cmd_shift),
      .DdrPhyCsrCmdTdrUpdateEn     (cmd_upd),
      .DdrPhyCsrCmdTdr_Tdo         (cmd_tdo),
      .DdrPhyCsrRdDataTdrCaptureEn (rd_cap),
      .DdrPhyCsrRdDataTdrShiftEn   (rd_shift),
      .DdrPhyCsrRdDataTdrUpdateEn  (rd_upd),
      .DdrPhyCsrRdDataTdr_Tdo      (rd_tdo),
      .csr                         (csr_if.master),
      .CsrTdrOverrun               (ovr),
      .CsrTdrTimeout               (tmo)
   );

   always #5 TDRCLK = ~TDRCLK;

   task automatic step();
      @(posedge TDRCLK);
      #1;
   endtask

   task automatic shift_cmd(input logic [44:0] v);
      for (int i = 0; i < 45; i++) begin
         WSI = v[i];
         cmd_shift = 1'b1;
         step();
      end
      cmd_shift = 1'b0;
      WSI = 1'b0;
   endtask

   task automatic pulse_cmd_update();
      cmd_upd = 1'b1;
      step();
      cmd_upd = 1'b0;
   endtask

   task automatic send_ack(input logic [15:0] d);
      csr_if.CsrAck = 1'b1;
      csr_if.CsrRdData = d;
      step();
      csr_if.CsrAck = 1'b0;
      csr_if.CsrRdData = 16'h0;
   endtask

   task automatic read_rd_tdr(output logic [15:0] v);
      rd_cap = 1'b1;
      step();
      rd_cap = 1'b0;
      for (int i = 0; i < 16; i++) begin
         v[i] = rd_tdo;
         rd_shift = 1'b1;
         step();
      end
      rd_shift = 1'b0;
   endtask

   task automatic read_cmd_tdr(output logic [44:0] v);
      for (int i = 0; i < 45; i++) begin
         v[i] = cmd_tdo;
         cmd_shift = 1'b1;
         step();
      end
      cmd_shift = 1'b0;
   endtask

   task automatic test_reset();
      TDRRST = 1'b1; cmd_shift = 1'b1; WSI = 1'b1; rd_shift = 1'b1;
      step();
      TDRRST = 1'b0; cmd_shift = 1'b0; WSI = 1'b0; rd_shift = 1'b0;
      checks++; if (cmd_tdo !== 1'b0) begin errors++; $display("FAIL reset_cmd_tdo got %b exp 0", cmd_tdo); end
      checks++; if (rd_tdo !== 1'b0) begin errors++; $display("FAIL reset_rd_tdo got %b exp 0", rd_tdo); end
      checks++; if (csr_if.CsrWrEn !== 1'b0) begin errors++; $display("FAIL reset_wren got %b exp 0", csr_if.CsrWrEn); end
      checks++; if (csr_if.CsrRdEn !== 1'b0) begin errors++; $display("FAIL reset_rden got %b exp 0", csr_if.CsrRdEn); end
      checks++; if (csr_if.CsrAddr !== 28'h0) begin errors++; $display("FAIL reset_addr got %h exp 0", csr_if.CsrAddr); end
      checks++; if (csr_if.CsrWrData !== 16'h0) begin errors++; $display("FAIL reset_wrdata got %h exp 0", csr_if.CsrWrData); end
      checks++; if (ovr !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b exp 0", ovr); end
      checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b exp 0", tmo); end
   endtask

   task automatic test_write();
      logic [44:0] c;
      logic [15:0] r;
      c = {16'hA5C3, 1'b1, 28'h0012345};
      shift_cmd(c);
      checks++; if (cmd_tdo !== 1'b1) begin errors++; $display("FAIL wr_shift_tdo got %b exp 1", cmd_tdo); end
      pulse_cmd_update();
      checks++; if (csr_if.CsrWrEn !== 1'b1) begin errors++; $display("FAIL wr_wren got %b exp 1", csr_if.CsrWrEn); end
      checks++; if (csr_if.CsrRdEn !== 1'b0) begin errors++; $display("FAIL wr_rden got %b exp 0", csr_if.CsrRdEn); end
      checks++; if (csr_if.CsrAddr !== 28'h0012345) begin errors++; $display("FAIL wr_addr got %h exp 0012345", csr_if.CsrAddr); end
      checks++; if (csr_if.CsrWrData !== 16'hA5C3) begin errors++; $display("FAIL wr_data got %h exp a5c3", csr_if.CsrWrData); end
      repeat (3) step();
      checks++; if (csr_if.CsrWrEn !== 1'b1) begin errors++; $display("FAIL wr_wren_wait got %b exp 1", csr_if.CsrWrEn); end
      send_ack(16'hFFFF);
      checks++; if (csr_if.CsrWrEn !== 1'b0) begin errors++; $display("FAIL wr_wren_done got %b exp 0", csr_if.CsrWrEn); end
      checks++; if (csr_if.CsrAddr !== 28'h0) begin errors++; $display("FAIL wr_addr_idle got %h exp 0", csr_if.CsrAddr); end
      checks++; if (csr_if.CsrWrData !== 16'h0) begin errors++; $display("FAIL wr_data_idle got %h exp 0", csr_if.CsrWrData); end
      read_rd_tdr(r);
      checks++; if (r !== 16'h0000) begin errors++; $display("FAIL wr_hold_unchanged got %h exp 0000", r); end
   endtask

   task automatic test_capture_shift();
      logic [44:0] got;
      cmd_cap = 1'b1; cmd_shift = 1'b1; WSI = 1'b1;
      step();
      cmd_cap = 1'b0; cmd_shift = 1'b0; WSI = 1'b0;
      read_cmd_tdr(got);
      checks++; if (got !== {16'hA5C3, 1'b1, 28'h0012345}) begin errors++; $display("FAIL cap_beats_shift got %h exp %h", got, {16'hA5C3, 1'b1, 28'h0012345}); end
   endtask

   task automatic test_read();
      logic [15:0] r;
      shift_cmd({16'h0000, 1'b0, 28'h0000400});
      pulse_cmd_update();
      checks++; if (csr_if.CsrRdEn !== 1'b1) begin errors++; $display("FAIL rd_rden got %b exp 1", csr_if.CsrRdEn); end
      checks++; if (csr_if.CsrWrEn !== 1'b0) begin errors++; $display("FAIL rd_wren got %b exp 0", csr_if.CsrWrEn); end
      checks++; if (csr_if.CsrAddr !== 28'h0000400) begin errors++; $display("FAIL rd_addr got %h exp 0000400", csr_if.CsrAddr); end
      repeat (4) step();
      checks++; if (csr_if.CsrRdEn !== 1'b1) begin errors++; $display("FAIL rd_rden_wait got %b exp 1", csr_if.CsrRdEn); end
      send_ack(16'h1234);
      checks++; if (csr_if.CsrRdEn !== 1'b0) begin errors++; $display("FAIL rd_rden_done got %b exp 0", csr_if.CsrRdEn); end
      read_rd_tdr(r);
      checks++; if (r !== 16'h1234) begin errors++; $display("FAIL rd_tdo_seq got %h exp 1234", r); end
      checks++; if (rd_tdo !== 1'b0) begin errors++; $display("FAIL rd_zero_fill got %b exp 0", rd_tdo); end
   endtask

   task automatic test_ack_in_req();
      logic [15:0] r;
      shift_cmd({16'hFFFF, 1'b0, 28'h0ABCDEF});
      pulse_cmd_update();
      checks++; if (csr_if.CsrWrData !== 16'h0) begin errors++; $display("FAIL req_rd_wrdata got %h exp 0", csr_if.CsrWrData); end
      send_ack(16'hBEEF);
      checks++; if (csr_if.CsrRdEn !== 1'b0) begin errors++; $display("FAIL req_ack_done got %b exp 0", csr_if.CsrRdEn); end
      send_ack(16'h1111);
      read_rd_tdr(r);
      checks++; if (r !== 16'hBEEF) begin errors++; $display("FAIL idle_ack_ignored got %h exp beef", r); end
   endtask

   task automatic test_overrun();
      logic [44:0] got;
      shift_cmd({16'h0000, 1'b0, 28'h0000777});
      pulse_cmd_update();
      step();
      shift_cmd({16'h1357, 1'b1, 28'h0000999});
      pulse_cmd_update();
      checks++; if (ovr !== 1'b1) begin errors++; $display("FAIL ovr_set got %b exp 1", ovr); end
      checks++; if (csr_if.CsrAddr !== 28'h0000777) begin errors++; $display("FAIL ovr_addr got %h exp 0000777", csr_if.CsrAddr); end
      checks++; if (csr_if.CsrWrEn !== 1'b0) begin errors++; $display("FAIL ovr_wren got %b exp 0", csr_if.CsrWrEn); end
      send_ack(16'h5A5A);
      checks++; if (ovr !== 1'b1) begin errors++; $display("FAIL ovr_sticky got %b exp 1", ovr); end
      cmd_cap = 1'b1;
      step();
      cmd_cap = 1'b0;
      read_cmd_tdr(got);
      checks++; if (got !== {16'h0000, 1'b0, 28'h0000777}) begin errors++; $display("FAIL ovr_last_cmd got %h exp %h", got, {16'h0000, 1'b0, 28'h0000777}); end
      rd_upd = 1'b1;
      step();
      rd_upd = 1'b0;
      checks++; if (ovr !== 1'b0) begin errors++; $display("FAIL ovr_clear got %b exp 0", ovr); end
   endtask

   task automatic test_reset_mid();
      logic [15:0] r;
      logic [44:0] got;
      shift_cmd({16'h0000, 1'b0, 28'h0000123});
      pulse_cmd_update();
      repeat (2) step();
      TDRRST = 1'b1;
      step();
      TDRRST = 1'b0;
      checks++; if (csr_if.CsrRdEn !== 1'b0) begin errors++; $display("FAIL rstmid_rden got %b exp 0", csr_if.CsrRdEn); end
      checks++; if (csr_if.CsrAddr !== 28'h0) begin errors++; $display("FAIL rstmid_addr got %h exp 0", csr_if.CsrAddr); end
      send_ack(16'hFFFF);
      checks++; if (csr_if.CsrRdEn !== 1'b0) begin errors++; $display("FAIL rstmid_late_ack got %b exp 0", csr_if.CsrRdEn); end
      read_rd_tdr(r);
      checks++; if (r !== 16'h0000) begin errors++; $display("FAIL rstmid_hold got %h exp 0000", r); end
      cmd_cap = 1'b1;
      step();
      cmd_cap = 1'b0;
      read_cmd_tdr(got);
      checks++; if (got !== 45'h0) begin errors++; $display("FAIL rstmid_cmd got %h exp 0", got); end
   endtask

`ifdef JTAG_TDR_CSR_TIMEOUT_EN
   task automatic test_timeout();
      logic [15:0] r;
      int n;
      shift_cmd({16'h0000, 1'b0, 28'h0000055});
      pulse_cmd_update();
      n = 0;
      while (csr_if.CsrRdEn === 1'b1 && n < 300) begin
         step();
         n++;
      end
      checks++; if (n != 256) begin errors++; $display("FAIL tmo_cycles got %0d exp 256", n); end
      checks++; if (tmo !== 1'b1) begin errors++; $display("FAIL tmo_flag got %b exp 1", tmo); end
      read_rd_tdr(r);
      checks++; if (r !== 16'hDEAD) begin errors++; $display("FAIL tmo_data got %h exp dead", r); end
      rd_upd = 1'b1;
      step();
      rd_upd = 1'b0;
      checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL tmo_clear got %b exp 0", tmo); end
   endtask
`else
   task automatic test_timeout();
      logic [15:0] r;
      shift_cmd({16'h0000, 1'b0, 28'h0000055});
      pulse_cmd_update();
      repeat (300) step();
      checks++; if (csr_if.CsrRdEn !== 1'b1) begin errors++; $display("FAIL wait_hold got %b exp 1", csr_if.CsrRdEn); end
      checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL tmo_tied got %b exp 0", tmo); end
      send_ack(16'h0F0F);
      checks++; if (csr_if.CsrRdEn !== 1'b0) begin errors++; $display("FAIL wait_done got %b exp 0", csr_if.CsrRdEn); end
      read_rd_tdr(r);
      checks++; if (r !== 16'h0F0F) begin errors++; $display("FAIL wait_data got %h exp 0f0f", r); end
   endtask
`endif

   initial begin
      TDRRST = 1'b1; WSI = 1'b0;
      cmd_cap = 1'b0; cmd_shift = 1'b0; cmd_upd = 1'b0;
      rd_cap = 1'b0; rd_shift = 1'b0; rd_upd = 1'b0;
      csr_if.CsrAck = 1'b0;
      csr_if.CsrRdData = 16'h0;
      step();
      step();
      test_reset();
      test_write();
      test_capture_shift();
      test_read();
      test_ack_in_req();
      test_overrun();
      test_reset_mid();
      test_timeout();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/jtag_tdr_csr_tgt.md
JTAG_TDR_CSR_TGT -- requirements
Module: jtag_tdr_csr_tgt

Interface
REQ-001 SHALL provide TDRCLK  in  1  TDR clock; sole clock, all state updates on its rising edge.
REQ-002 SHALL provide TDRRST  in  1  reset, synchronous, active-high.
REQ-003 SHALL provide WSI  in  1  TDR serial data in, LSB first.
REQ-004 SHALL provide DdrPhyCsrCmdTdrCaptureEn / DdrPhyCsrCmdTdrShiftEn / DdrPhyCsrCmdTdrUpdateEn  in  1 each  command TDR controls.
REQ-005 SHALL provide DdrPhyCsrCmdTdr_Tdo  out  1  command TDR serial out.
REQ-006 SHALL provide DdrPhyCsrRdDataTdrCaptureEn / DdrPhyCsrRdDataTdrShiftEn / DdrPhyCsrRdDataTdrUpdateEn  in  1 each  read-data TDR controls.
REQ-007 SHALL provide DdrPhyCsrRdDataTdr_Tdo  out  1  read-data TDR serial out.
REQ-008 SHALL provide CsrAddr  out  28, CsrWrData  out  16, CsrWrEn  out  1, CsrRdEn  out  1  CSR request.
REQ-009 SHALL provide CsrAck  in  1, CsrRdData  in  16  CSR completion; CsrRdData valid when CsrAck is high.
REQ-010 SHALL provide CsrTdrOverrun  out  1 (sticky) and CsrTdrTimeout  out  1 (sticky) status.

Function
REQ-011 Command shift register SHALL be 45 bits: [27:0] addr, [28] write flag, [44:29] data.
REQ-012 Each edge with CmdShiftEn high SHALL shift right: sr <= {WSI, sr[44:1]}; DdrPhyCsrCmdTdr_Tdo = sr[0] (registered bit, no combinational path from WSI).
REQ-013 CmdCaptureEn high SHALL load sr with the last accepted command; capture beats shift on the same edge.
REQ-014 CmdUpdateEn sampled high with FSM IDLE SHALL latch sr into the command register and move FSM IDLE->REQ.
REQ-015 CmdUpdateEn sampled high with FSM not IDLE SHALL drop the command and set CsrTdrOverrun.
REQ-016 FSM states IDLE, REQ, WAIT: REQ drives CsrAddr/CsrWrData and exactly one of CsrWrEn (flag=1) or CsrRdEn (flag=0) from the next cycle; REQ->WAIT after one cycle; enables held high through WAIT until CsrAck sampled high; WAIT->IDLE on that edge; enables low next cycle.
REQ-017 CsrAck in REQ SHALL complete immediately (REQ->IDLE); CsrAck in IDLE SHALL be ignored.
REQ-018 On a read completion, CsrRdData SHALL be captured into a 16-bit read-hold register; write completion leaves it unchanged.
REQ-019 Update-to-request latency: request visible 1 cycle after the UpdateEn edge.
REQ-020 RdDataCaptureEn high SHALL load the 16-bit read-data shift register from read-hold; capture beats shift.
REQ-021 Each edge with RdDataShiftEn high SHALL shift right inserting 0; DdrPhyCsrRdDataTdr_Tdo = rsr[0].
REQ-022 RdDataUpdateEn SHALL clear CsrTdrOverrun and CsrTdrTimeout; no other effect.
REQ-023 CsrWrData SHALL be 0 during reads; CsrAddr/CsrWrData SHALL be 0 in IDLE.

Reset
REQ-024 TDRRST high at an edge SHALL clear all shift, command and hold registers, FSM->IDLE, all outputs 0 from the following cycle, including mid-transaction (request dropped, no completion recorded).
REQ-025 TDRRST SHALL take priority over all TDR controls and CsrAck.

Configuration
REQ-026 Macro JTAG_TDR_CSR_TIMEOUT_EN defined: 8-bit counter in WAIT; 255 cycles in WAIT without CsrAck -> FSM to IDLE, enables dropped, CsrTdrTimeout set, read-hold loaded 16'hDEAD for reads.
REQ-027 Macro undefined: no counter, WAIT holds indefinitely, CsrTdrTimeout tied 0.

Verification
REQ-028 Shift 45 bits of {16'hA5C3,1'b1,28'h0012345}, pulse update -> CsrWrEn=1, CsrAddr=28'h0012345, CsrWrData=16'hA5C3 from next cycle until CsrAck.
REQ-029 Read addr 28'h0000400, CsrAck after 5 cycles with CsrRdData=16'h1234, RdData capture+16 shifts -> Tdo sequence LSB first equals 16'h1234.
REQ-030 Second update while in WAIT -> command ignored, CsrTdrOverrun=1; RdDataUpdateEn pulse -> 0.
REQ-031 TDRRST asserted in WAIT -> CsrRdEn=0 next cycle, later CsrAck ignored, read-hold=0.
REQ-032 With JTAG_TDR_CSR_TIMEOUT_EN, read with no CsrAck -> IDLE after 255 WAIT cycles, CsrTdrTimeout=1, shifted read data 16'hDEAD.
REQ-033 Capture and shift asserted together on command TDR -> sr equals last accepted command, no shift that edge.
